// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM state type.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b010000;
  localparam logic [5:0] ALU_SUB   = 6'b010001;
  localparam logic [5:0] ALU_MUL   = 6'b010010;
  localparam logic [5:0] ALU_AND   = 6'b101000;
  localparam logic [5:0] ALU_OR    = 6'b101110;
  localparam logic [5:0] ALU_XOR   = 6'b100110;
  localparam logic [5:0] ALU_XNOR  = 6'b101001;
  localparam logic [5:0] ALU_PASSA = 6'b101010;
  localparam logic [5:0] ALU_SHL   = 6'b100000;
  localparam logic [5:0] ALU_SHR   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_CMPEQ = 6'b110011;
  localparam logic [5:0] ALU_CMPLT = 6'b110101;
  localparam logic [5:0] ALU_CMPLE = 6'b110111;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits
// of the unsigned product. done pulses in the cycle of the final iteration and
// product is valid alongside it, so the caller can capture on that same edge.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic [WIDTH-1:0] acc_next_s;
  logic             last_s;

  // Next partial sum and last-iteration detect.
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
    last_s = busy_r && (cnt_r == CW'(WIDTH - 1));
  end

  assign done    = last_s;
  assign product = acc_next_s;

  // Operand load on start, then one shift-add step per cycle until WIDTH bits are consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
    end else if (start && !busy_r) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      busy_r   <= !last_s;
    end else begin
      busy_r   <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and a single registered result slot.
// Single-cycle ops complete with latency 1; MUL (only when ALU_SEQ_MUL_EN is
// defined) runs through an iterative multiplier and completes WIDTH+1 cycles
// after acceptance. Without ALU_SEQ_MUL_EN the MUL code is reported as illegal.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alufn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             illegal
);

  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic             out_valid_r;
  logic [WIDTH-1:0] y_r;
  logic             z_r, n_r, c_r, v_r, ill_r;

  logic             accept_s;
  logic             is_mul_s;
  logic [WIDTH-1:0] res_y_s;
  logic             res_c_s, res_v_s, res_ill_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [SHW-1:0]   shamt_s;
  logic             slot_free_s;

`ifdef ALU_SEQ_MUL_EN
  state_t           state_r;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .a       (a),
    .b       (b),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  assign mul_start_s = accept_s && is_mul_s;
  assign in_ready    = !rst && (state_r == IDLE) && slot_free_s;
`else
  assign in_ready    = !rst && slot_free_s;
`endif

  assign slot_free_s = !out_valid_r || out_ready;
  assign accept_s    = in_valid && in_ready;

  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign z         = z_r;
  assign n         = n_r;
  assign c         = c_r;
  assign v         = v_r;
  assign illegal   = ill_r;

  // Opcode decode and single-cycle datapath.
  always_comb begin
    res_y_s   = {WIDTH{1'b0}};
    res_c_s   = 1'b0;
    res_v_s   = 1'b0;
    res_ill_s = 1'b0;
    is_mul_s  = 1'b0;
    sum_s     = {1'b0, a} + {1'b0, b};
    // a - b as a + ~b + 1 so the top bit is the not-borrow
    diff_s    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    shamt_s   = b[SHW-1:0];
    case (alufn)
      ALU_ADD: begin
        res_y_s = sum_s[WIDTH-1:0];
        res_c_s = sum_s[WIDTH];
        res_v_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_y_s = diff_s[WIDTH-1:0];
        res_c_s = diff_s[WIDTH];
        res_v_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
`ifdef ALU_SEQ_MUL_EN
      ALU_MUL:   is_mul_s = 1'b1;
`endif
      ALU_AND:   res_y_s = a & b;
      ALU_OR:    res_y_s = a | b;
      ALU_XOR:   res_y_s = a ^ b;
      ALU_XNOR:  res_y_s = ~(a ^ b);
      ALU_PASSA: res_y_s = a;
      ALU_SHL:   res_y_s = a << shamt_s;
      ALU_SHR:   res_y_s = a >> shamt_s;
      ALU_SRA:   res_y_s = $unsigned($signed(a) >>> shamt_s);
      ALU_CMPEQ: res_y_s = {{(WIDTH-1){1'b0}}, (a == b)};
      ALU_CMPLT: res_y_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_CMPLE: res_y_s = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
      default:   res_ill_s = 1'b1;
    endcase
  end

  // Control state and output slot: load on single-cycle accept or multiply
  // completion, clear valid on transfer out, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      y_r         <= {WIDTH{1'b0}};
      z_r         <= 1'b0;
      n_r         <= 1'b0;
      c_r         <= 1'b0;
      v_r         <= 1'b0;
      ill_r       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      state_r     <= IDLE;
`endif
    end else begin
      if (accept_s && !is_mul_s) begin
        out_valid_r <= 1'b1;
        y_r         <= res_y_s;
        z_r         <= (res_y_s == {WIDTH{1'b0}});
        n_r         <= res_y_s[WIDTH-1];
        c_r         <= res_c_s;
        v_r         <= res_v_s;
        ill_r       <= res_ill_s;
`ifdef ALU_SEQ_MUL_EN
      end else if (mul_done_s) begin
        out_valid_r <= 1'b1;
        y_r         <= mul_prod_s;
        z_r         <= (mul_prod_s == {WIDTH{1'b0}});
        n_r         <= mul_prod_s[WIDTH-1];
        c_r         <= 1'b0;
        v_r         <= 1'b0;
        ill_r       <= 1'b0;
`endif
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
`ifdef ALU_SEQ_MUL_EN
      case (state_r)
        IDLE: begin
          if (accept_s && is_mul_s) begin
            state_r <= MUL_BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        MUL_BUSY: begin
          if (mul_done_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= MUL_BUSY;
          end
        end
        default: state_r <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): table-driven vectors through a
// scoreboard queue, plus hand-written backpressure, multiply and reset sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int NV    = 19;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       alufn;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             z, n, c, v, illegal;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        z, n, c, v, il;
    int          lat;
  } vec_t;

  typedef struct {
    logic [36:0] res;
    int          acc;
    int          lat;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   chk_lat = 1'b1;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alufn(alufn), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .z(z), .n(n), .c(c), .v(v), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output monitor: every transfer out is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {27'd0, y, z, n, c, v, illegal}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {27'd0, y, z, n, c, v, illegal}, {27'd0, e.res});
        if (chk_lat) chk("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic send(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] ey, input logic ez, input logic en, input logic ec,
                      input logic ev, input logic eil, input int lat);
    bit done = 1'b0;
    alufn = fn; a = av; b = bv; in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.res = {ey, ez, en, ec, ev, eil};
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{ALU_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{ALU_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{ALU_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{ALU_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{ALU_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{ALU_OR,    32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{ALU_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{ALU_XNOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{ALU_PASSA, 32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{ALU_SHL,   32'h00000001, 32'hFFFFFFE3, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{ALU_SHR,   32'h80000000, 32'h00000021, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{ALU_SRA,   32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{ALU_CMPEQ, 32'h00000007, 32'h00000007, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{ALU_CMPLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{ALU_CMPLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{ALU_CMPLE, 32'h00000005, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[16] = '{6'b111111,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[17] = '{ALU_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
`ifdef ALU_SEQ_MUL_EN
    vecs[18] = '{ALU_MUL,   32'h00000003, 32'h00000005, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WIDTH + 1};
`else
    vecs[18] = '{ALU_MUL,   32'h00000003, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
`endif

    // Reset state
    rst = 1'b1; in_valid = 1'b0; alufn = 6'd0; a = 32'd0; b = 32'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_outputs", {26'd0, out_valid, y, z, n, c, v, illegal}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Table vectors, back to back
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].y,
           vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, vecs[i].il, vecs[i].lat);
    end
    drain();

    // Backpressure: SRA result held for 5 cycles, then a simultaneous in/out transfer
    chk_lat = 1'b0;
    out_ready = 1'b0;
    send(ALU_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_hold", {30'd0, out_valid, in_ready, y}, {30'd0, 1'b1, 1'b0, 32'hF8000000});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      begin
        #2;
        send(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      end
    join
    drain();
    chk_lat = 1'b1;

`ifdef ALU_SEQ_MUL_EN
    // Multiply: in_ready low for the whole busy period
    begin
      int bad = 0;
      send(ALU_MUL, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WIDTH + 1);
      for (int k = 0; k < WIDTH; k++) begin
        @(negedge clk);
        if (in_ready !== 1'b0) bad++;
      end
      chk("mul_busy_in_ready", bad, 64'd0);
      drain();
    end
    // Reset during multiply aborts it
    send(ALU_MUL, 32'h00000007, 32'h00000009, 32'h0000003F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WIDTH + 1);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {31'd0, out_valid, y}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
`else
    // Reset drops a result stuck behind backpressure
    out_ready = 1'b0;
    send(ALU_ADD, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {31'd0, out_valid, y}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
`endif
    send(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 alufn  input  6  operation code.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 y  output  WIDTH  result.
REQ-011 z, n, c, v  output  1 each  zero, negative, carry/not-borrow, signed overflow flags.
REQ-012 illegal  output  1  accepted alufn was not a supported code.

Function
REQ-013 Codes: ADD 010000, SUB 010001, MUL 010010, AND 101000, OR 101110, XOR 100110, XNOR 101001, PASSA 101010, SHL 100000, SHR 100001, SRA 100011, CMPEQ 110011, CMPLT 110101 (signed), CMPLE 110111 (signed).
REQ-014 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-015 in_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-016 States: IDLE, MUL_BUSY; IDLE->MUL_BUSY on accepted MUL; MUL_BUSY->IDLE when the iteration count reaches WIDTH.
REQ-017 Non-MUL ops: y/flags/illegal registered at acceptance edge; out_valid high the next cycle (latency 1); back-to-back throughput 1/cycle when out_ready is held high.
REQ-018 MUL: iterative shift-add, one bit per cycle, y = low WIDTH bits of a*b (unsigned); out_valid asserts exactly WIDTH+1 cycles after acceptance; in_ready low throughout MUL_BUSY.
REQ-019 ADD/SUB: WIDTH-bit wraparound; c = carry-out (ADD) or NOT borrow (SUB); v = signed overflow; all other ops drive c=v=0.
REQ-020 Shifts use b[$clog2(WIDTH)-1:0] only; upper bits of b ignored; SRA replicates a[WIDTH-1].
REQ-021 Compares: y = {WIDTH-1 zeros, result bit}.
REQ-022 z = (y == 0), n = y[WIDTH-1] for every op.
REQ-023 Unsupported alufn: accepted, y=0, z=1, n=c=v=0, illegal=1, latency 1.
REQ-024 Backpressure: while out_valid && !out_ready, y/flags/illegal hold stable and no new request is accepted.
REQ-025 Output register clears out_valid on transfer out unless a new result loads the same edge (simultaneous in/out transfer keeps out_valid high with new data).

Reset
REQ-026 rst high at an edge: state=IDLE, out_valid=0, y=0, z=n=c=v=0, illegal=0, multiplier counter/accumulator cleared.
REQ-027 rst during MUL_BUSY aborts the multiply; no result is ever produced for it.
REQ-028 in_ready is 0 while rst is high.

Configuration
REQ-029 Macro ALU_SEQ_MUL_EN: defined -> MUL supported per REQ-018; undefined -> MUL_BUSY state and multiplier absent, 010010 handled as illegal per REQ-023.

Structure
REQ-030 Shared package alu_pkg holds the alufn code constants and the state enum typedef.
REQ-031 Multiplier is sub-module alu_mul_iter (start, a, b -> done, product), instantiated only under ALU_SEQ_MUL_EN.

Verification
REQ-032 WIDTH=32, ADD a=0x7FFFFFFF b=1 -> next cycle y=0x80000000, v=1, n=1, c=0, z=0.
REQ-033 SUB a=5 b=5 -> y=0, z=1, c=1; SUB a=0 b=1 -> y=0xFFFFFFFF, c=0, n=1.
REQ-034 MUL a=0x10001 b=0x10001 (macro on) -> out_valid exactly 33 cycles after acceptance, y=0x00020001; in_ready low meanwhile.
REQ-035 out_ready low 5 cycles with result SRA a=0x80000000 b=4 pending -> y=0xF8000000 held stable, in_ready=0, no loss.
REQ-036 alufn=111111 -> y=0, illegal=1; macro off, alufn=010010 -> illegal=1, latency 1.
REQ-037 rst asserted mid-MUL (cycle 10) -> next cycle out_valid=0, y=0; subsequent ADD 2+3 -> y=5 with latency 1.
